uart_cmd_parser: RTL

- Sits directly downstream of the UART receiver. Consumes its byte stream (`rx_data`, plus the `rx_valid` one-cycle strobe).
- Parses ASCII into two kinds of output:
  - stopwatch commands: one-cycle pulses.
  - calculator expressions of the form `<A><op><B><term>`: latched operands, an operator code and a `expr_valid` strobe.
- Feeds the stopwatch control FSM and the calculator ALU. Only the byte stream is needed; no UART timing.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/ascii_char_class.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the UART command parser and the calculator datapath:
// operator codes, ASCII constants and the parser state encoding.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;

  typedef enum logic [1:0] {
    StIdle,
    StOpa,
    StOpb0,
    StOpb
  } parse_state_e;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier for one received byte: exactly one class output is
// set for any input value.
module ascii_char_class (
  input  logic [7:0] data,
  output logic       is_digit,
  output logic [3:0] digit_val,
  output logic       is_op,
  output logic [1:0] op_code,
  output logic       is_term,
  output logic       is_ignore,
  output logic       is_esc,
  output logic       cmd_s,
  output logic       cmd_p,
  output logic       cmd_r,
  output logic       is_invalid
);
  import calc_pkg::*;

  always_comb begin
    is_digit  = (data >= 8'h30) && (data <= 8'h39);
    digit_val = data[3:0];
    is_op     = 1'b1;
    op_code   = OP_ADD;
    case (data)
      ASCII_PLUS:  op_code = OP_ADD;
      ASCII_MINUS: op_code = OP_SUB;
      ASCII_STAR:  op_code = OP_MUL;
      ASCII_SLASH: op_code = OP_DIV;
      default:     is_op   = 1'b0;
    endcase
    is_term    = (data == ASCII_CR) || (data == ASCII_EQ);
    is_ignore  = (data == ASCII_SPACE) || (data == ASCII_LF);
    is_esc     = (data == ASCII_ESC);
    cmd_s      = (data == 8'h53) || (data == 8'h73);
    cmd_p      = (data == 8'h50) || (data == 8'h70);
    cmd_r      = (data == 8'h52) || (data == 8'h72);
    is_invalid = !(is_digit || is_op || is_term || is_ignore || is_esc ||
                   cmd_s || cmd_p || cmd_r);
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses the UART byte stream into stopwatch command pulses and calculator
// expressions <A><op><B><term>. All outputs are registered (one-cycle latency).
module uart_cmd_parser #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_code,
  output logic             expr_valid,
  output logic             cmd_start,
  output logic             cmd_pause,
  output logic             cmd_reset,
  output logic             err
);
  import calc_pkg::*;

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic       is_digit, is_op, is_term, is_ignore, is_esc, is_invalid;
  logic       cmd_s, cmd_p, cmd_r;
  logic [3:0] digit_val;
  logic [1:0] char_op;

  ascii_char_class u_class (
    .data       (rx_data),
    .is_digit   (is_digit),
    .digit_val  (digit_val),
    .is_op      (is_op),
    .op_code    (char_op),
    .is_term    (is_term),
    .is_ignore  (is_ignore),
    .is_esc     (is_esc),
    .cmd_s      (cmd_s),
    .cmd_p      (cmd_p),
    .cmd_r      (cmd_r),
    .is_invalid (is_invalid)
  );

  parse_state_e     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       opc_q, opc_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]       op_code_q, op_code_d;
  logic             expr_valid_q, expr_valid_d, start_q, start_d, pause_q, pause_d;
  logic             reset_q, reset_d, err_q, err_d;

  logic [WIDTH-1:0] acc_next;
  logic             digit_full;

  assign acc_next   = acc_q * WIDTH'(10) + WIDTH'(digit_val);
  assign digit_full = (cnt_q == CntW'(MAX_DIGITS));

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    opc_d        = opc_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    expr_valid_d = 1'b0;
    start_d      = 1'b0;
    pause_d      = 1'b0;
    reset_d      = 1'b0;
    err_d        = 1'b0;
    if (rx_valid && !is_ignore) begin
      if (is_esc) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (is_digit) begin
              acc_d   = WIDTH'(digit_val);
              cnt_d   = CntW'(1);
              state_d = StOpa;
            end else if (cmd_s) begin
              start_d = 1'b1;
            end else if (cmd_p) begin
              pause_d = 1'b1;
            end else if (cmd_r) begin
              reset_d = 1'b1;
            end else if (is_op || is_invalid) begin
              err_d = 1'b1;
            end
          end
          StOpa, StOpb: begin
            // A digit beyond MAX_DIGITS falls through to the error branch.
            if (is_digit && !digit_full) begin
              acc_d = acc_next;
              cnt_d = cnt_q + CntW'(1);
            end else if (state_q == StOpa && is_op) begin
              a_d     = acc_q;
              opc_d   = char_op;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StOpb0;
            end else if (state_q == StOpb && is_term) begin
              op_a_d       = a_q;
              op_b_d       = acc_q;
              op_code_d    = opc_q;
              expr_valid_d = 1'b1;
              state_d      = StIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
          StOpb0: begin
            if (is_digit) begin
              acc_d   = WIDTH'(digit_val);
              cnt_d   = CntW'(1);
              state_d = StOpb;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      opc_q        <= OP_ADD;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= OP_ADD;
      expr_valid_q <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      reset_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      opc_q        <= opc_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      expr_valid_q <= expr_valid_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
      reset_q      <= reset_d;
      err_q        <= err_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_code    = op_code_q;
  assign expr_valid = expr_valid_q;
  assign cmd_start  = start_q;
  assign cmd_pause  = pause_q;
  assign cmd_reset  = reset_q;
  assign err        = err_q;

endmodule
